// File: rtl/i2c_cfg_pkg.sv
// Shared state encoding and constants for the I2C configuration sequencer.
package i2c_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      GAP,
      DONE,
      ERROR
   } cfg_state_e;

   localparam int unsigned I2C_WR_BYTES   = 3;
   localparam logic [7:0]  CODEC_DEV_ADDR = 8'h34;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/i2c_cfg_gap_timer.sv
// Loadable down-counter shared by the inter-write gap and the WAIT watchdog.
module i2c_cfg_gap_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_last
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // A load of 0 or 1 both expire on the first counted cycle.
   assign o_last = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks an external register table, issuing one 3-byte I2C write per entry with NACK retry.
// Optional watchdog in WAIT is enabled by defining I2C_TIMEOUT_EN.
module i2c_cfg_sequencer
   import i2c_cfg_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 11,
   parameter int unsigned IDX_W       = 8,
   parameter logic [7:0]  DEV_ADDR    = CODEC_DEV_ADDR,
   parameter int unsigned RETRY_MAX   = 3,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned AUTO_START  = 1,
   parameter int unsigned TIMEOUT_CYC = 2**20
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      go,
   output logic [IDX_W-1:0]          cfg_index,
   input  logic [15:0]               cfg_data,
   output logic [I2C_WR_BYTES*8-1:0] i2c_data,
   output logic                      i2c_start,
   input  logic                      i2c_done,
   input  logic                      i2c_ack,
   output logic                      busy,
   output logic                      cfg_done,
   output logic                      cfg_error,
   output logic [IDX_W-1:0]          err_index,
   output logic [IDX_W-1:0]          status
);

   localparam int unsigned      CNT_W     = $clog2(max_u(max_u(GAP_CYCLES, TIMEOUT_CYC), 2) + 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [3:0]       RETRY_LIM = 4'(RETRY_MAX);
`ifdef I2C_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT_CYC);
`endif

   cfg_state_e                  r_state, w_state_nxt;
   logic [IDX_W-1:0]            r_index, w_index_nxt;
   logic [I2C_WR_BYTES*8-1:0]   r_data, w_data_nxt;
   logic                        r_start, w_start_nxt;
   logic                        r_done, w_done_nxt;
   logic                        r_error, w_error_nxt;
   logic [IDX_W-1:0]            r_err_index, w_err_index_nxt;
   logic [3:0]                  r_retry, w_retry_nxt, w_retry_inc;
   logic                        r_auto;
   logic                        w_go;
   logic                        w_nack;
   logic                        w_tmr_load, w_tmr_dec, w_tmr_last;
   logic [CNT_W-1:0]            w_tmr_val;

   i2c_cfg_gap_timer #(
      .CNT_W (CNT_W)
   ) u_gap_timer (
      .i_clk      (clk),
      .i_rst_n    (reset_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_dec      (w_tmr_dec),
      .o_last     (w_tmr_last)
   );

   // The first clock after reset release behaves as a go pulse when auto-start is set.
   assign w_go = go | r_auto;

`ifdef I2C_TIMEOUT_EN
   assign w_nack = i2c_done ? !i2c_ack : w_tmr_last;
`else
   assign w_nack = i2c_done & !i2c_ack;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_index_nxt     = r_index;
      w_data_nxt      = r_data;
      w_start_nxt     = 1'b0;
      w_done_nxt      = r_done;
      w_error_nxt     = r_error;
      w_err_index_nxt = r_err_index;
      w_retry_nxt     = r_retry;
      w_retry_inc     = r_retry + 4'd1;
      w_tmr_load      = 1'b0;
      w_tmr_val       = GAP_LOAD;
      w_tmr_dec       = 1'b0;

      unique case (r_state)
         IDLE, DONE, ERROR: begin
            if (w_go) begin
               w_state_nxt = LOAD;
               w_index_nxt = '0;
               w_retry_nxt = '0;
               w_done_nxt  = 1'b0;
               w_error_nxt = 1'b0;
            end
         end
         LOAD: begin
            w_data_nxt  = {DEV_ADDR, cfg_data};
            w_start_nxt = 1'b1;
            w_state_nxt = START;
         end
         START: begin
            w_state_nxt = WAIT;
`ifdef I2C_TIMEOUT_EN
            w_tmr_load  = 1'b1;
            w_tmr_val   = TMO_LOAD;
`endif
         end
         WAIT: begin
            w_tmr_dec = 1'b1;
            if (i2c_done && i2c_ack) begin
               w_state_nxt = GAP;
               w_retry_nxt = '0;
               w_tmr_load  = 1'b1;
               w_tmr_val   = GAP_LOAD;
            end else if (w_nack) begin
               w_retry_nxt = w_retry_inc;
               if (w_retry_inc == RETRY_LIM) begin
                  w_state_nxt     = ERROR;
                  w_error_nxt     = 1'b1;
                  w_err_index_nxt = r_index;
               end else begin
                  w_state_nxt = LOAD;
               end
            end
         end
         GAP: begin
            w_tmr_dec = 1'b1;
            if (w_tmr_last) begin
               if (r_index == LAST_IDX) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = LOAD;
                  w_index_nxt = r_index + IDX_W'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_index     <= '0;
         r_data      <= '0;
         r_start     <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_err_index <= '0;
         r_retry     <= '0;
         r_auto      <= (AUTO_START != 0);
      end else begin
         r_state     <= w_state_nxt;
         r_index     <= w_index_nxt;
         r_data      <= w_data_nxt;
         r_start     <= w_start_nxt;
         r_done      <= w_done_nxt;
         r_error     <= w_error_nxt;
         r_err_index <= w_err_index_nxt;
         r_retry     <= w_retry_nxt;
         r_auto      <= 1'b0;
      end
   end

   assign cfg_index = r_index;
   assign status    = r_index;
   assign i2c_data  = r_data;
   assign i2c_start = r_start;
   assign cfg_done  = r_done;
   assign cfg_error = r_error;
   assign err_index = r_err_index;
   assign busy      = (r_state == LOAD) || (r_state == START) ||
                      (r_state == WAIT) || (r_state == GAP);

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Scoreboard bench for i2c_cfg_sequencer: expected writes are queued by the stimulus and
// checked by a monitor on every i2c_start; an I2C responder model supplies done/ack.
module tb_i2c_cfg_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        go;
   logic [7:0]  cfg_index;
   logic [15:0] cfg_data;
   logic [23:0] i2c_data;
   logic        i2c_start;
   logic        i2c_done;
   logic        i2c_ack;
   logic        busy;
   logic        cfg_done;
   logic        cfg_error;
   logic [7:0]  err_index;
   logic [7:0]  status;

   typedef struct {
      logic [7:0]  idx;
      logic [23:0] data;
      int          gap;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   starts = 0;
   int   nack_idx = -1;
   int   nack_num = 0;
   int   nack_given = 0;
   int   stop_idx = -1;
   int   s0;

   always #5 clk = ~clk;

   i2c_cfg_sequencer #(
      .NUM_REGS    (11),
      .IDX_W       (8),
      .DEV_ADDR    (8'h34),
      .RETRY_MAX   (3),
      .GAP_CYCLES  (4),
      .AUTO_START  (1),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .go        (go),
      .cfg_index (cfg_index),
      .cfg_data  (cfg_data),
      .i2c_data  (i2c_data),
      .i2c_start (i2c_start),
      .i2c_done  (i2c_done),
      .i2c_ack   (i2c_ack),
      .busy      (busy),
      .cfg_done  (cfg_done),
      .cfg_error (cfg_error),
      .err_index (err_index),
      .status    (status)
   );

   function automatic logic [15:0] rom(input logic [7:0] i);
      case (i)
         8'd0:    return 16'h0410;
         8'd1:    return 16'h0A00;
         8'd2:    return 16'h0C00;
         8'd3:    return 16'h0E02;
         8'd4:    return 16'h1001;
         8'd5:    return 16'h1201;
         8'd6:    return 16'h0017;
         8'd7:    return 16'h0217;
         8'd8:    return 16'h0879;
         8'd9:    return 16'h0679;
         8'd10:   return 16'h0C01;
         default: return 16'h0000;
      endcase
   endfunction

   assign cfg_data = rom(cfg_index);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int idx, input int gap);
      exp_t e;
      e.idx  = 8'(idx);
      e.data = {8'h34, rom(8'(idx))};
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic pulse_go();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      for (int i = 0; i < bound && !cfg_done; i++) @(negedge clk);
      check(name, 32'(cfg_done), 32'd1);
   endtask

   // Monitor: every start pulse pops one expected write and compares index, data and spacing.
   initial begin
      int cyc = 0;
      int last = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (i2c_start) begin
            starts++;
            check("start_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("start_index", 32'(cfg_index), 32'(e.idx));
               check("start_data", 32'(i2c_data), 32'(e.data));
               if (e.gap > 0) check("start_spacing", 32'(cyc - last), 32'(e.gap));
            end
            last = cyc;
         end
      end
   end

   // Responder: done/ack three cycles after each start; NACK plan and a silent index.
   initial begin
      i2c_done = 1'b0;
      i2c_ack  = 1'b0;
      forever begin
         @(negedge clk);
         if (i2c_start && int'(cfg_index) != stop_idx) begin
            logic a;
            repeat (3) @(negedge clk);
            a = !(int'(cfg_index) == nack_idx && nack_given < nack_num);
            if (!a) nack_given++;
            i2c_done = 1'b1;
            i2c_ack  = a;
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_ack  = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      go      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_index", 32'(cfg_index), 32'd0);
      check("rst_data", 32'(i2c_data), 32'd0);
      check("rst_start", 32'(i2c_start), 32'd0);
      check("rst_flags", 32'({cfg_done, cfg_error}), 32'd0);
      check("rst_err_index", 32'(err_index), 32'd0);

      // 1: auto-start run, always ACK.
      push(0, 0);
      for (int i = 1; i < 11; i++) push(i, 9);
      s0 = starts;
      reset_n = 1'b1;
      wait_done("t1_done", 1000);
      check("t1_starts", 32'(starts - s0), 32'd11);
      check("t1_status", 32'(status), 32'd10);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_error", 32'(cfg_error), 32'd0);

      // 2: go after DONE, entry 3 NACKed twice then ACKed.
      repeat (5) @(negedge clk);
      nack_idx = 3; nack_num = 2; nack_given = 0;
      push(0, 0); push(1, 9); push(2, 9); push(3, 9); push(3, 5); push(3, 5);
      for (int i = 4; i < 11; i++) push(i, 9);
      s0 = starts;
      pulse_go();
      check("t2_done_cleared", 32'(cfg_done), 32'd0);
      check("t2_index0", 32'(cfg_index), 32'd0);
      check("t2_start_early", 32'(i2c_start), 32'd0);
      check("t2_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t2_start_latency", 32'(i2c_start), 32'd1);
      wait_done("t2_done", 1000);
      check("t2_starts", 32'(starts - s0), 32'd13);

      // 3: entry 5 always NACKed; a go during WAIT must be ignored.
      repeat (5) @(negedge clk);
      nack_idx = 5; nack_num = 1000; nack_given = 0;
      push(0, 0);
      for (int i = 1; i < 6; i++) push(i, 9);
      push(5, 5); push(5, 5);
      s0 = starts;
      pulse_go();
      for (int i = 0; i < 50 && (starts - s0) < 2; i++) @(negedge clk);
      @(negedge clk);
      pulse_go();
      for (int i = 0; i < 1000 && !cfg_error; i++) @(negedge clk);
      check("t3_error", 32'(cfg_error), 32'd1);
      check("t3_err_index", 32'(err_index), 32'd5);
      check("t3_busy", 32'(busy), 32'd0);
      check("t3_done", 32'(cfg_done), 32'd0);
      repeat (30) @(negedge clk);
      check("t3_starts", 32'(starts - s0), 32'd8);

      // 5: asynchronous reset while waiting on entry 7, then auto-start rerun.
      nack_idx = -1; nack_num = 0; stop_idx = 7;
      for (int i = 0; i < 8; i++) push(i, (i == 0) ? 0 : 9);
      s0 = starts;
      pulse_go();
      for (int i = 0; i < 500 && (starts - s0) < 8; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("t5_busy_wait", 32'(busy), 32'd1);
      check("t5_index7", 32'(cfg_index), 32'd7);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      #1 reset_n = 1'b0;
      #1;
      check("t5_async_busy", 32'(busy), 32'd0);
      check("t5_async_index", 32'(cfg_index), 32'd0);
      check("t5_async_data", 32'(i2c_data), 32'd0);
      repeat (2) @(negedge clk);
      stop_idx = -1;
      push(0, 0);
      for (int i = 1; i < 11; i++) push(i, 9);
      s0 = starts;
      reset_n = 1'b1;
      wait_done("t5_rerun_done", 1000);
      check("t5_rerun_starts", 32'(starts - s0), 32'd11);

      // 6: controller never answers.
      repeat (5) @(negedge clk);
      stop_idx = 0;
      push(0, 0);
`ifdef I2C_TIMEOUT_EN
      push(0, 102); push(0, 102);
`endif
      s0 = starts;
      pulse_go();
      repeat (400) @(negedge clk);
`ifdef I2C_TIMEOUT_EN
      check("t6_error", 32'(cfg_error), 32'd1);
      check("t6_err_index", 32'(err_index), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_starts", 32'(starts - s0), 32'd3);
`else
      check("t6_busy", 32'(busy), 32'd1);
      check("t6_error", 32'(cfg_error), 32'd0);
      check("t6_index", 32'(cfg_index), 32'd0);
      check("t6_starts", 32'(starts - s0), 32'd1);
`endif
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
